// File: rtl/mult_6x6.sv
// Unsigned 6x6 Vedic (Urdhva Tiryagbhyam) multiplier with registered 12-bit product.
// Define MULT_6X6_PIPE_EN to register the sub-products as well (latency 2 instead of 1).
module mult_6x6 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  A,
  input  logic [5:0]  B,
  output logic        out_valid,
  output logic [11:0] p
);

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // 3x3 vertical/crosswise columns; each result is {carry, sum}, carries ripple upward
  function automatic logic [5:0] vedic3(input logic [2:0] a, input logic [2:0] b);
    logic [1:0] c1, c2a, c2b, c3a, c3b, c4;
    c1  = ha(a[1] & b[0], a[0] & b[1]);
    c2a = fa(a[2] & b[0], a[1] & b[1], a[0] & b[2]);
    c2b = ha(c2a[0], c1[1]);
    c3a = fa(a[2] & b[1], a[1] & b[2], c2a[1]);
    c3b = ha(c3a[0], c2b[1]);
    c4  = fa(a[2] & b[2], c3a[1], c3b[1]);
    return {c4[1], c4[0], c3b[0], c2b[0], c1[0], a[0] & b[0]};
  endfunction

  function automatic logic [11:0] recombine(input logic [5:0] q0, input logic [5:0] q1,
                                            input logic [5:0] q2, input logic [5:0] q3);
    logic [6:0] mid;
    mid = {1'b0, q1} + {1'b0, q2};
    return {6'b000000, q0} + {2'b00, mid, 3'b000} + {q3, 6'b000000};
  endfunction

  logic [5:0]  w_q0, w_q1, w_q2, w_q3;
  logic [11:0] w_p;
  logic        w_v;
  logic [11:0] r_p;
  logic        r_v;

  assign w_q0 = vedic3(A[2:0], B[2:0]);
  assign w_q1 = vedic3(A[5:3], B[2:0]);
  assign w_q2 = vedic3(A[2:0], B[5:3]);
  assign w_q3 = vedic3(A[5:3], B[5:3]);

`ifdef MULT_6X6_PIPE_EN
  logic [5:0] r_q0, r_q1, r_q2, r_q3;
  logic       r_v1;

  // First stage: capture the four sub-products and their valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= 6'd0;
      r_q1 <= 6'd0;
      r_q2 <= 6'd0;
      r_q3 <= 6'd0;
      r_v1 <= 1'b0;
    end else begin
      r_q0 <= w_q0;
      r_q1 <= w_q1;
      r_q2 <= w_q2;
      r_q3 <= w_q3;
      r_v1 <= in_valid;
    end
  end

  assign w_p = recombine(r_q0, r_q1, r_q2, r_q3);
  assign w_v = r_v1;
`else
  assign w_p = recombine(w_q0, w_q1, w_q2, w_q3);
  assign w_v = in_valid;
`endif

  // Output stage: product only advances on a valid pair, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= 12'h000;
      r_v <= 1'b0;
    end else begin
      r_v <= w_v;
      if (w_v) begin
        r_p <= w_p;
      end else begin
        r_p <= r_p;
      end
    end
  end

  assign p         = r_p;
  assign out_valid = r_v;

endmodule

// File: tb/tb_mult_6x6.sv
// Scoreboard bench for mult_6x6: driver pushes expected products, a negedge monitor checks them.
module tb_mult_6x6;

`ifdef MULT_6X6_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [11:0] p;
    int          cyc;
    logic [5:0]  a;
    logic [5:0]  b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  A;
  logic [5:0]  B;
  logic        out_valid;
  logic [11:0] p;

  exp_t        sb[$];
  int          total;
  int          bad;
  int          cyc;
  logic [11:0] last_p;

  mult_6x6 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .p        (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  // Drive one pair just after a rising edge; it is sampled at the next edge
  task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic v,
                       input logic [11:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    in_valid = v;
    if (v) begin
      e.p   = expv;
      e.cyc = cyc + LAT;
      e.a   = a;
      e.b   = b;
      sb.push_back(e);
    end
  endtask

  // Monitor: pop and compare on every valid output, check hold and reset state otherwise
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      total++;
      if (p !== 12'h000 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
      end
      last_p = 12'h000;
    end else if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: p=%0d out_valid=1 at cycle %0d, required no output", p, cyc);
      end else begin
        e = sb.pop_front();
        if (p !== e.p || cyc != e.cyc) begin
          bad++;
          $display("FAIL product %0d*%0d: p=%0d at cycle %0d, required p=%0d at cycle %0d",
                   e.a, e.b, p, cyc, e.p, e.cyc);
        end
      end
      last_p = p;
    end else begin
      total++;
      if (p !== last_p || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold: p=%0d out_valid=%b, required p=%0d out_valid=0", p, out_valid, last_p);
      end
    end
  end

  logic [5:0]  da [12] = '{6'd28, 6'd42, 6'd7,  6'd12, 6'd37, 6'd49, 6'd37, 6'd0,  6'd63, 6'd1,  6'd8, 6'd7};
  logic [5:0]  db [12] = '{6'd11, 6'd18, 6'd12, 6'd10, 6'd20, 6'd34, 6'd24, 6'd63, 6'd63, 6'd45, 6'd8, 6'd7};
  logic [11:0] dp [12] = '{12'd308, 12'd756, 12'd84, 12'd120, 12'd740, 12'd1666, 12'd888,
                           12'd0, 12'hF81, 12'd45, 12'd64, 12'd49};

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    last_p   = 12'h000;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 6'd0;
    B        = 6'd0;

    // Reset held with random operands and in_valid high
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      A = 6'($urandom_range(0, 63));
      B = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Directed vectors and corners, streamed back-to-back
    for (int i = 0; i < 12; i++) drive(da[i], db[i], 1'b1, dp[i]);

    // Gaps: alternate valid/invalid with changing operands
    drive(6'd5,  6'd9,  1'b1, 12'd45);
    drive(6'd60, 6'd61, 1'b0, 12'd0);
    drive(6'd33, 6'd3,  1'b1, 12'd99);
    drive(6'd17, 6'd40, 1'b0, 12'd0);
    drive(6'd21, 6'd21, 1'b1, 12'd441);
    drive(6'd2,  6'd50, 1'b0, 12'd0);
    drive(6'd2,  6'd50, 1'b0, 12'd0);

    // Mid-stream reset between edges with products in flight
    drive(6'd44, 6'd55, 1'b1, 12'd2420);
    drive(6'd30, 6'd30, 1'b1, 12'd900);
    drive(6'd63, 6'd62, 1'b1, 12'd3906);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    total++;
    if (p !== 12'h000 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) drive(6'd11, 6'd13, 1'b0, 12'd0);
    drive(6'd11, 6'd13, 1'b1, 12'd143);

    // Exhaustive sweep against the arithmetic reference
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        drive(6'(a), 6'(b), 1'b1, 12'(a * b));
      end
    end
    drive(6'd0, 6'd0, 1'b0, 12'd0);

    repeat (LAT + 3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, required pending=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
